// File: rtl/ddr_bist_pkg.sv
// Shared types and constants for the DDR BIST engine.
package ddr_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CHECK,
    ST_DONE
  } bist_state_t;

  localparam logic [1:0] PAT_INC     = 2'd0;
  localparam logic [1:0] PAT_INV     = 2'd1;
  localparam logic [1:0] PAT_WALK1   = 2'd2;
  localparam logic [1:0] PAT_CHECKER = 2'd3;

endpackage

// File: rtl/ddr_bist_pattern.sv
// Data pattern generator: (mode, burst, beat) -> beat data, purely combinational.
module ddr_bist_pattern
  import ddr_bist_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 512,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned BURST_NUM_W   = 19
) (
  input  logic [1:0]               i_mode,
  input  logic [BURST_NUM_W-1:0]   i_burst,
  input  logic [7:0]               i_beat,
  output logic [MEM_DATA_BITS-1:0] o_data
);

  localparam int unsigned VW    = BURST_NUM_W + 8;
  localparam int unsigned LANES = MEM_DATA_BITS / 32;
  localparam int unsigned BYTES = MEM_DATA_BITS / 8;

  logic [VW-1:0] w_v;
  logic [VW-1:0] w_bit;
  logic [31:0]   w_lane;

  assign w_v    = VW'(i_burst) * VW'(BURST_LEN) + VW'(i_beat);
  assign w_bit  = w_v % VW'(MEM_DATA_BITS);
  assign w_lane = ~(32'(w_v));

  always_comb begin
    o_data = '0;
    case (i_mode)
      PAT_INC:   o_data = MEM_DATA_BITS'(w_v);
      PAT_INV:   o_data = {LANES{w_lane}};
      PAT_WALK1: begin
        for (int unsigned i = 0; i < MEM_DATA_BITS; i++) o_data[i] = (w_bit == VW'(i));
      end
      default:   o_data = w_v[0] ? {BYTES{8'hAA}} : {BYTES{8'h55}};
    endcase
  end

endmodule

// File: rtl/ddr_bist_engine.sv
// DDR BIST engine: writes N bursts of a pattern, reads them back, compares and reports.
module ddr_bist_engine
  import ddr_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 28,
  parameter int unsigned MEM_DATA_BITS = 512,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned LINE_SHIFT    = 9,
  parameter int unsigned BURST_NUM_W   = 19
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_n_i,
  input  logic                     test_start_i,
  input  logic                     test_stop_i,
  input  logic [1:0]               test_mode_i,
  input  logic [BURST_NUM_W-1:0]   burst_num_i,
  input  logic                     loop_en_i,
  output logic                     wr_ddr_req_o,
  output logic [7:0]               wr_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]    wr_ddr_addr_o,
  input  logic                     ddr_fifo_rd_req_i,
  output logic [MEM_DATA_BITS-1:0] wr_ddr_data_o,
  input  logic                     wr_ddr_finish_i,
  output logic                     rd_ddr_req_o,
  output logic [7:0]               rd_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]    rd_ddr_addr_o,
  input  logic                     rd_ddr_data_valid_i,
  input  logic [MEM_DATA_BITS-1:0] rd_ddr_data_i,
  input  logic                     rd_ddr_finish_i,
  output logic                     test_busy_o,
  output logic                     test_done_o,
  output logic                     test_pass_o,
  output logic [31:0]              err_cnt_o,
  output logic [BURST_NUM_W+7:0]   first_err_o,
  output logic [15:0]              pass_cnt_o
);

  localparam logic [7:0] LEN = 8'(BURST_LEN);

  bist_state_t              r_state;
  logic [BURST_NUM_W-1:0]   r_burst_num, r_burst, r_cmp_burst;
  logic [1:0]               r_mode;
  logic                     r_loop, r_stop;
  logic [7:0]               r_wr_beat, r_rd_beat, r_cmp_beat;
  logic                     r_cmp_vld;
  logic [MEM_DATA_BITS-1:0] r_cmp_data, r_wr_data;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic                     r_wr_req, r_rd_req, r_busy, r_done, r_pass;
  logic [31:0]              r_err_cnt;
  logic [BURST_NUM_W+7:0]   r_first_err;
  logic [15:0]              r_pass_cnt;

  logic                     w_in_wr, w_in_rd, w_wr_fin, w_rd_fin, w_wr_adv, w_rd_vld;
  logic                     w_last, w_stop, w_start, w_wr_load, w_err_cmp, w_err_short;
  logic [BURST_NUM_W-1:0]   w_burst_inc, w_wr_pat_burst;
  logic [ADDR_WIDTH-1:0]    w_addr_inc;
  logic [7:0]               w_wr_pat_beat, w_rd_beat_inc;
  logic [1:0]               w_wr_pat_mode;
  logic [8:0]               w_rd_cnt;
  logic [32:0]              w_err_sum;
  logic [MEM_DATA_BITS-1:0] w_wr_pat, w_exp;

  assign w_in_wr     = (r_state == ST_WR_REQ) || (r_state == ST_WR_WAIT);
  assign w_in_rd     = (r_state == ST_RD_REQ) || (r_state == ST_RD_WAIT);
  assign w_wr_fin    = w_in_wr && wr_ddr_finish_i;
  assign w_rd_fin    = w_in_rd && rd_ddr_finish_i;
  assign w_wr_adv    = w_in_wr && ddr_fifo_rd_req_i && !wr_ddr_finish_i;
  assign w_rd_vld    = w_in_rd && rd_ddr_data_valid_i;
  assign w_last      = (r_burst == r_burst_num - BURST_NUM_W'(1));
  assign w_burst_inc = r_burst + BURST_NUM_W'(1);
  assign w_addr_inc  = ADDR_WIDTH'(w_burst_inc) << LINE_SHIFT;
  assign w_stop      = r_stop || test_stop_i;
  assign w_start     = (r_state == ST_IDLE) && test_start_i && (burst_num_i != '0);

  // Write data is preloaded so beat k is on the bus before the k-th FIFO pop.
  assign w_wr_pat_mode  = w_start ? test_mode_i : r_mode;
  assign w_wr_pat_burst = w_wr_fin ? w_burst_inc : (w_wr_adv ? r_burst : '0);
  assign w_wr_pat_beat  = w_wr_adv ? r_wr_beat + 8'd1 : 8'd0;
  assign w_wr_load      = w_start || w_wr_adv || (w_wr_fin && !w_last && !w_stop) ||
                          ((r_state == ST_DONE) && r_loop && !w_stop);

  // Compare stage runs one cycle behind capture; beats past BURST_LEN are errors.
  assign w_rd_beat_inc = (r_rd_beat == 8'hFF) ? r_rd_beat : r_rd_beat + 8'd1;
  assign w_rd_cnt      = {1'b0, r_rd_beat} + 9'(rd_ddr_data_valid_i);
  assign w_err_cmp     = r_cmp_vld && ((r_cmp_beat >= LEN) || (r_cmp_data != w_exp));
  assign w_err_short   = w_rd_fin && (w_rd_cnt < 9'(BURST_LEN));
  assign w_err_sum     = {1'b0, r_err_cnt} + 33'(w_err_cmp) + 33'(w_err_short);

  ddr_bist_pattern #(.MEM_DATA_BITS(MEM_DATA_BITS), .BURST_LEN(BURST_LEN), .BURST_NUM_W(BURST_NUM_W))
    u_wr_pat (.i_mode(w_wr_pat_mode), .i_burst(w_wr_pat_burst), .i_beat(w_wr_pat_beat), .o_data(w_wr_pat));

  ddr_bist_pattern #(.MEM_DATA_BITS(MEM_DATA_BITS), .BURST_LEN(BURST_LEN), .BURST_NUM_W(BURST_NUM_W))
    u_rd_pat (.i_mode(r_mode), .i_burst(r_cmp_burst), .i_beat(r_cmp_beat), .o_data(w_exp));

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      r_state     <= ST_IDLE;
      r_burst_num <= '0;
      r_burst     <= '0;
      r_cmp_burst <= '0;
      r_mode      <= '0;
      r_loop      <= 1'b0;
      r_stop      <= 1'b0;
      r_wr_beat   <= '0;
      r_rd_beat   <= '0;
      r_cmp_beat  <= '0;
      r_cmp_vld   <= 1'b0;
      r_cmp_data  <= '0;
      r_wr_data   <= '0;
      r_addr      <= '0;
      r_wr_req    <= 1'b0;
      r_rd_req    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass_cnt  <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cmp_vld <= w_rd_vld;
      if (w_rd_vld) begin
        r_cmp_data  <= rd_ddr_data_i;
        r_cmp_burst <= r_burst;
        r_cmp_beat  <= r_rd_beat;
        r_rd_beat   <= w_rd_beat_inc;
      end
      if (w_wr_load) r_wr_data <= w_wr_pat;
      if (w_wr_adv) r_wr_beat <= w_wr_pat_beat;
      if ((r_state != ST_IDLE) && test_stop_i) r_stop <= 1'b1;
      if (w_err_cmp || w_err_short) begin
        r_err_cnt <= w_err_sum[32] ? '1 : w_err_sum[31:0];
        if (r_err_cnt == '0)
          r_first_err <= w_err_cmp ? {r_cmp_burst, r_cmp_beat} : {r_burst, w_rd_cnt[7:0]};
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_WR_REQ;
            r_burst_num <= burst_num_i;
            r_mode      <= test_mode_i;
            r_loop      <= loop_en_i;
            r_stop      <= 1'b0;
            r_burst     <= '0;
            r_addr      <= '0;
            r_wr_beat   <= '0;
            r_wr_req    <= 1'b1;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_pass_cnt  <= '0;
          end
        end
        ST_WR_REQ, ST_WR_WAIT: begin
          if (ddr_fifo_rd_req_i || wr_ddr_finish_i) r_wr_req <= 1'b0;
          if ((r_state == ST_WR_REQ) && ddr_fifo_rd_req_i) r_state <= ST_WR_WAIT;
          if (wr_ddr_finish_i) begin
            r_wr_beat <= '0;
            if (w_stop) begin
              r_state <= ST_DONE;
            end else if (w_last) begin
              r_state   <= ST_RD_REQ;
              r_burst   <= '0;
              r_addr    <= '0;
              r_rd_beat <= '0;
              r_rd_req  <= 1'b1;
            end else begin
              r_state  <= ST_WR_REQ;
              r_burst  <= w_burst_inc;
              r_addr   <= w_addr_inc;
              r_wr_req <= 1'b1;
            end
          end
        end
        ST_RD_REQ, ST_RD_WAIT: begin
          if (rd_ddr_data_valid_i || rd_ddr_finish_i) r_rd_req <= 1'b0;
          if ((r_state == ST_RD_REQ) && rd_ddr_data_valid_i) r_state <= ST_RD_WAIT;
          if (rd_ddr_finish_i) begin
            r_rd_beat <= '0;
            if (w_stop) begin
              r_state <= ST_DONE;
            end else if (w_last) begin
              r_state <= ST_CHECK;
            end else begin
              r_state  <= ST_RD_REQ;
              r_burst  <= w_burst_inc;
              r_addr   <= w_addr_inc;
              r_rd_req <= 1'b1;
            end
          end
        end
        ST_CHECK: r_state <= ST_DONE;
        ST_DONE: begin
          r_done <= 1'b1;
          r_pass <= (r_err_cnt == '0) && !r_stop;
          if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 16'd1;
          if (r_loop && !w_stop) begin
            r_state   <= ST_WR_REQ;
            r_burst   <= '0;
            r_addr    <= '0;
            r_wr_beat <= '0;
            r_wr_req  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_ddr_req_o  = r_wr_req;
  assign wr_ddr_len_o  = LEN;
  assign wr_ddr_addr_o = r_addr;
  assign wr_ddr_data_o = r_wr_data;
  assign rd_ddr_req_o  = r_rd_req;
  assign rd_ddr_len_o  = LEN;
  assign rd_ddr_addr_o = r_addr;
  assign test_busy_o   = r_busy;
  assign test_done_o   = r_done;
  assign test_pass_o   = r_pass;
  assign err_cnt_o     = r_err_cnt;
  assign first_err_o   = r_first_err;
  assign pass_cnt_o    = r_pass_cnt;

endmodule

// File: tb/tb_ddr_bist_engine.sv
// Directed bench for ddr_bist_engine with a behavioural DDR model and fault injection.
module tb_ddr_bist_engine;

  logic         ddr_clk_i = 1'b0;
  logic         ddr_rst_n_i;
  logic         test_start_i, test_stop_i, loop_en_i;
  logic [1:0]   test_mode_i;
  logic [18:0]  burst_num_i;
  logic         wr_ddr_req_o, rd_ddr_req_o;
  logic [7:0]   wr_ddr_len_o, rd_ddr_len_o;
  logic [27:0]  wr_ddr_addr_o, rd_ddr_addr_o;
  logic         ddr_fifo_rd_req_i, wr_ddr_finish_i;
  logic [511:0] wr_ddr_data_o, rd_ddr_data_i;
  logic         rd_ddr_data_valid_i, rd_ddr_finish_i;
  logic         test_busy_o, test_done_o, test_pass_o;
  logic [31:0]  err_cnt_o;
  logic [26:0]  first_err_o;
  logic [15:0]  pass_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  int           cur_mode = 0;
  int           wr_bad   = 0;
  bit           flip_en  = 1'b0;
  int           flip_b, flip_k, flip_bit;
  int           len_b    = -1;
  int           len_n    = 64;
  logic [511:0] mem [int];
  logic [27:0]  wr_addrs [$];
  logic [27:0]  rd_addrs [$];

  ddr_bist_engine dut (
    .ddr_clk_i(ddr_clk_i), .ddr_rst_n_i(ddr_rst_n_i),
    .test_start_i(test_start_i), .test_stop_i(test_stop_i), .test_mode_i(test_mode_i),
    .burst_num_i(burst_num_i), .loop_en_i(loop_en_i),
    .wr_ddr_req_o(wr_ddr_req_o), .wr_ddr_len_o(wr_ddr_len_o), .wr_ddr_addr_o(wr_ddr_addr_o),
    .ddr_fifo_rd_req_i(ddr_fifo_rd_req_i), .wr_ddr_data_o(wr_ddr_data_o),
    .wr_ddr_finish_i(wr_ddr_finish_i),
    .rd_ddr_req_o(rd_ddr_req_o), .rd_ddr_len_o(rd_ddr_len_o), .rd_ddr_addr_o(rd_ddr_addr_o),
    .rd_ddr_data_valid_i(rd_ddr_data_valid_i), .rd_ddr_data_i(rd_ddr_data_i),
    .rd_ddr_finish_i(rd_ddr_finish_i),
    .test_busy_o(test_busy_o), .test_done_o(test_done_o), .test_pass_o(test_pass_o),
    .err_cnt_o(err_cnt_o), .first_err_o(first_err_o), .pass_cnt_o(pass_cnt_o)
  );

  always #5 ddr_clk_i = ~ddr_clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pattern written straight from the pattern definitions, 512-bit beats, 64-beat bursts.
  function automatic logic [511:0] pat(input int m, input int b, input int k);
    int v;
    logic [511:0] d;
    v = b * 64 + k;
    d = '0;
    case (m)
      0: d[31:0] = 32'(v);
      1: for (int i = 0; i < 16; i++) d[32*i +: 32] = ~(32'(v));
      2: d[v % 512] = 1'b1;
      default: d = v[0] ? {64{8'hAA}} : {64{8'h55}};
    endcase
    return d;
  endfunction

  task automatic serve_write();
    int b;
    b = int'(wr_ddr_addr_o >> 9);
    wr_addrs.push_back(wr_ddr_addr_o);
    for (int k = 0; k < 64; k++) begin
      mem[b*64+k] = wr_ddr_data_o;
      if (wr_ddr_data_o !== pat(cur_mode, b, k)) wr_bad++;
      ddr_fifo_rd_req_i = 1'b1;
      @(posedge ddr_clk_i); #1;
      ddr_fifo_rd_req_i = 1'b0;
      if (!ddr_rst_n_i) return;
    end
    wr_ddr_finish_i = 1'b1;
    @(posedge ddr_clk_i); #1;
    wr_ddr_finish_i = 1'b0;
  endtask

  task automatic serve_read();
    int b, n;
    logic [511:0] d;
    b = int'(rd_ddr_addr_o >> 9);
    rd_addrs.push_back(rd_ddr_addr_o);
    n = (b == len_b) ? len_n : 64;
    for (int k = 0; k < n; k++) begin
      d = mem.exists(b*64+k) ? mem[b*64+k] : '0;
      if (flip_en && b == flip_b && k == flip_k) d[flip_bit] = ~d[flip_bit];
      rd_ddr_data_i       = d;
      rd_ddr_data_valid_i = 1'b1;
      @(posedge ddr_clk_i); #1;
      rd_ddr_data_valid_i = 1'b0;
      if (!ddr_rst_n_i) return;
    end
    rd_ddr_finish_i = 1'b1;
    @(posedge ddr_clk_i); #1;
    rd_ddr_finish_i = 1'b0;
  endtask

  initial begin : ddr_model
    ddr_fifo_rd_req_i   = 1'b0;
    wr_ddr_finish_i     = 1'b0;
    rd_ddr_data_valid_i = 1'b0;
    rd_ddr_data_i       = '0;
    rd_ddr_finish_i     = 1'b0;
    forever begin
      @(posedge ddr_clk_i); #1;
      if (ddr_rst_n_i && wr_ddr_req_o) serve_write();
      else if (ddr_rst_n_i && rd_ddr_req_o) serve_read();
    end
  end

  task automatic start(input int n, input int m, input bit lp);
    burst_num_i  = 19'(n);
    test_mode_i  = 2'(m);
    loop_en_i    = lp;
    test_start_i = 1'b1;
    @(posedge ddr_clk_i); #1;
    test_start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge ddr_clk_i); #1;
      if (test_done_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  task automatic clear_log();
    wr_addrs.delete();
    rd_addrs.delete();
    wr_bad  = 0;
    flip_en = 1'b0;
    len_b   = -1;
  endtask

  initial begin : main
    bit seen;
    ddr_rst_n_i  = 1'b0;
    test_start_i = 1'b0;
    test_stop_i  = 1'b0;
    test_mode_i  = '0;
    burst_num_i  = '0;
    loop_en_i    = 1'b0;
    repeat (3) @(posedge ddr_clk_i);
    #1;
    chk("rst_busy",    64'(test_busy_o),  64'd0);
    chk("rst_wr_req",  64'(wr_ddr_req_o), 64'd0);
    chk("rst_rd_req",  64'(rd_ddr_req_o), 64'd0);
    chk("rst_done",    64'(test_done_o),  64'd0);
    chk("rst_pass",    64'(test_pass_o),  64'd0);
    chk("rst_err_cnt", 64'(err_cnt_o),    64'd0);
    chk("rst_wr_data", 64'(|wr_ddr_data_o), 64'd0);
    chk("len_const",   64'({wr_ddr_len_o, rd_ddr_len_o}), 64'h4040);
    ddr_rst_n_i = 1'b1;
    repeat (2) @(posedge ddr_clk_i);
    #1;

    // Four clean bursts, incrementing pattern; a second start while busy is ignored.
    clear_log();
    cur_mode = 0;
    start(4, 0, 1'b0);
    repeat (5) @(posedge ddr_clk_i);
    #1;
    start(7, 3, 1'b0);
    wait_done("t1_done");
    chk("t1_pass",     64'(test_pass_o), 64'd1);
    chk("t1_err_cnt",  64'(err_cnt_o),   64'd0);
    chk("t1_pass_cnt", 64'(pass_cnt_o),  64'd1);
    chk("t1_busy_off", 64'(test_busy_o), 64'd0);
    chk("t1_wr_data",  64'(wr_bad),      64'd0);
    chk("t1_n_wr",     64'(wr_addrs.size()), 64'd4);
    chk("t1_n_rd",     64'(rd_addrs.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_addrs.size() && i < rd_addrs.size(); i++) begin
      chk($sformatf("t1_wr_addr%0d", i), 64'(wr_addrs[i]), 64'(i * 512));
      chk($sformatf("t1_rd_addr%0d", i), 64'(rd_addrs[i]), 64'(i * 512));
    end
    @(posedge ddr_clk_i); #1;
    chk("t1_done_1cyc", 64'(test_done_o), 64'd0);

    // Zero burst count is ignored.
    start(0, 0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge ddr_clk_i); #1;
      seen |= test_busy_o | wr_ddr_req_o | rd_ddr_req_o;
    end
    chk("t2_zero_ignored", 64'(seen), 64'd0);

    // Walking-one with bit 3 of burst 1 beat 5 flipped on readback.
    clear_log();
    cur_mode = 2;
    flip_en  = 1'b1;
    flip_b   = 1;
    flip_k   = 5;
    flip_bit = 3;
    start(2, 2, 1'b0);
    wait_done("t3_done");
    chk("t3_err_cnt",   64'(err_cnt_o),   64'd1);
    chk("t3_first_err", 64'(first_err_o), 64'h105);
    chk("t3_pass",      64'(test_pass_o), 64'd0);
    chk("t3_wr_data",   64'(wr_bad),      64'd0);

    // 65 beats returned on burst 1.
    clear_log();
    cur_mode = 0;
    len_b    = 1;
    len_n    = 65;
    start(2, 0, 1'b0);
    wait_done("t4_done");
    chk("t4_err_cnt_65", 64'(err_cnt_o),   64'd1);
    chk("t4_pass",       64'(test_pass_o), 64'd0);

    // 63 beats returned on burst 1.
    clear_log();
    len_b = 1;
    len_n = 63;
    start(2, 0, 1'b0);
    wait_done("t5_done");
    chk("t5_err_cnt_63", 64'(err_cnt_o),   64'd1);
    chk("t5_pass",       64'(test_pass_o), 64'd0);

    // Looping single-burst checkerboard, stop during the third pass read.
    clear_log();
    cur_mode = 3;
    start(1, 3, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge ddr_clk_i); #1;
      if (pass_cnt_o == 16'd2 && rd_ddr_req_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_reach_pass3_rd", 64'(seen), 64'd1);
    test_stop_i = 1'b1;
    @(posedge ddr_clk_i); #1;
    test_stop_i = 1'b0;
    wait_done("t6_done");
    chk("t6_pass_cnt", 64'(pass_cnt_o),  64'd3);
    chk("t6_pass",     64'(test_pass_o), 64'd0);
    chk("t6_busy_off", 64'(test_busy_o), 64'd0);
    chk("t6_err_cnt",  64'(err_cnt_o),   64'd0);
    chk("t6_n_rd",     64'(rd_addrs.size()), 64'd3);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ddr_clk_i); #1;
      seen |= wr_ddr_req_o | rd_ddr_req_o;
    end
    chk("t6_no_new_req", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of write burst 2, then a clean inverted-pattern run.
    clear_log();
    cur_mode = 1;
    start(4, 1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge ddr_clk_i); #1;
      if (wr_ddr_addr_o == 28'h400 && !wr_ddr_req_o && test_busy_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t7_reach_wr2", 64'(seen), 64'd1);
    repeat (3) @(posedge ddr_clk_i);
    #2;
    ddr_rst_n_i = 1'b0;
    #1;
    chk("t7_rst_busy",    64'(test_busy_o),   64'd0);
    chk("t7_rst_wr_req",  64'(wr_ddr_req_o),  64'd0);
    chk("t7_rst_addr",    64'(wr_ddr_addr_o), 64'd0);
    chk("t7_rst_wr_data", 64'(|wr_ddr_data_o), 64'd0);
    chk("t7_rst_err_cnt", 64'(err_cnt_o),     64'd0);
    chk("t7_rst_pass_cnt", 64'(pass_cnt_o),   64'd0);
    repeat (2) @(posedge ddr_clk_i);
    #3;
    ddr_rst_n_i = 1'b1;
    @(posedge ddr_clk_i); #1;
    clear_log();
    start(4, 1, 1'b0);
    wait_done("t7_done");
    chk("t7_pass",     64'(test_pass_o), 64'd1);
    chk("t7_err_cnt",  64'(err_cnt_o),   64'd0);
    chk("t7_wr_data",  64'(wr_bad),      64'd0);
    chk("t7_pass_cnt", 64'(pass_cnt_o),  64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
